bus_arbiter2: RTL and testbench
===============================

// Module: bus_arbiter2
// PURPOSE
//  Two-master, one-slave Wishbone (pipelined) arbiter feeding the shared bus consumed by bus_slave_if decoders.
//  Grants bus ownership round-robin for a whole cycle (cyc high), tracks outstanding requests,
//  throttles issue at a depth limit and aborts hung cycles with err after a timeout.
// PARAMETERS
//  MAX_OUTSTANDING  4     max issued-but-unacked requests; stall granted master at limit (>=1)
//  TIMEOUT          255   cycles with outstanding>0 and no ack/err before abort; 0 disables
// PORTS
//  clk          in   1    single clock, all state on posedge
//  rst          in   1    reset: asynchronous, active-low
//  m0_cyc,m0_stb,m0_we in 1 master 0 cycle/strobe/write
//  m0_addr      in   30   master 0 word address (BUS_ADDRWIDTH)
//  m0_data_m2s  in   32   master 0 write data
//  m0_sel       in   4    master 0 byte selects
//  m0_data_s2m  out  32   read data (broadcast from slave)
//  m0_ack,m0_err,m0_stall out 1 master 0 responses
//  m1_*         --   --   identical set for master 1
//  s_cyc,s_stb,s_we out 1 downstream cycle/strobe/write
//  s_addr out 30; s_data_m2s out 32; s_sel out 4   downstream request fields
//  s_data_s2m   in   32   downstream read data
//  s_ack,s_err,s_stall in 1 downstream responses
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, last=1 (m0 wins first tie), outstanding=0, timer=0;
//   s_cyc=s_stb=s_we=0, s_addr/s_data_m2s/s_sel=0; mX_ack=mX_err=0, mX_stall=1. s_cyc drops immediately.
//  States: IDLE, GNT0, GNT1, TERM.
//  IDLE: all masters stalled, downstream idle. Both cyc high -> GNT of !last; one high -> GNT of it.
//   Transition registered: 1-cycle arbitration latency, first stb accepted earliest cycle after cyc rise.
//  GNTx: s_cyc/s_we/s_addr/s_data_m2s/s_sel = mx_* combinationally; s_stb = mx_stb & !full;
//   mx_stall = s_stall | full; full = (outstanding==MAX_OUTSTANDING); mx_ack = s_ack & !s_err;
//   mx_err = s_err | tmo. Non-granted master: stall=1, ack=err=0. mX_data_s2m = s_data_s2m always.
//   mx_cyc low -> IDLE next cycle, last<=x, outstanding<=0, timer<=0 (abort: late acks dropped).
//   Master may hold cyc across back-to-back requests; no preemption while cyc high.
//  outstanding: +1 on s_stb&!s_stall, -1 on s_ack|s_err, both same cycle -> unchanged;
//   width $clog2(MAX_OUTSTANDING+1); never exceeds MAX, never underflows (ack at 0 ignored).
//  Timer: +1 each cycle with outstanding>0 and no ack/err; cleared on ack/err or outstanding==0.
//   timer==TIMEOUT-1 (TIMEOUT>0) -> tmo=1 that cycle: one-cycle mx_err pulse, outstanding<=0, ->TERM.
//  TERM: s_cyc=0, mx_stall=1, ack/err=0; stays until owning mx_cyc low -> IDLE, last<=owner.
//  s_ack and s_err together: err wins, counts as one completion.
//  Requires mx_cyc to stay high until its acks return; dropping early is an abort, not an error.
// STRUCTURE
//  bus_pkg: BUS_DATAWIDTH/ADDRWIDTH/SELWIDTH constants, typedef enum logic[1:0] arb_state_e
//   {ARB_IDLE,ARB_GNT0,ARB_GNT1,ARB_TERM}.
//  Sub-module bus_txn_tracker: outstanding counter + timeout timer; in issue/done/clear,
//   out full/tmo. Top holds FSM, round-robin pointer and muxes.
// TESTING
//  1 reset release, m0 cyc+stb addr=0x10 single read, slave ack 2 cyc later data=0xDEADBEEF
//    -> s_cyc rises 1 cycle after m0_cyc, m0_ack with 0xDEADBEEF, m1_stall=1 throughout.
//  2 m0,m1 cyc same cycle from reset -> GNT0; m0 drops cyc -> IDLE then GNT1; repeat -> GNT0 (alternates).
//  3 MAX_OUTSTANDING=4, slave never acks, m0 streams 6 stbs -> exactly 4 s_stb accepted, m0_stall=1 after
//    4th; one ack -> 5th issued.
//  4 TIMEOUT=8, one request, no ack -> m0_err pulse 1 cycle 8 cycles after issue, s_cyc=0 until m0_cyc
//    low; late ack ignored.
//  5 s_ack & s_err same cycle with outstanding=1 -> m0_err=1, m0_ack=0, outstanding=0.
//  6 rst asserted mid-burst (outstanding=3) -> s_cyc/s_stb low same cycle, all outputs at reset values.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus constants and the arbiter state encoding.
package bus_pkg;

    localparam int BUS_DATAWIDTH = 32;
    localparam int BUS_ADDRWIDTH = 30;
    localparam int BUS_SELWIDTH  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2,
        ARB_TERM = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bus_txn_tracker.sv
// Outstanding-request counter and hung-cycle timer for the granted master.
module bus_txn_tracker #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_i,   // request accepted downstream this cycle
    input  logic          done_i,    // ack or err seen this cycle
    input  logic          clear_i,   // drop all tracking state
    output logic          full_o,
    output logic          tmo_o,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          busy;

    assign busy    = (count_q != '0);
    assign full_o  = (count_q == CW'(MAX_OUTSTANDING));
    assign count_o = count_q;
    // A completion arriving on the last allowed cycle rescues the transfer.
    assign tmo_o   = (TIMEOUT != 0) && busy && !done_i && (timer_q == TW'(TIMEOUT - 1));

    // Next count/timer: simultaneous issue+done cancel; done at zero is ignored.
    always_comb begin
        count_d = count_q;
        timer_d = timer_q;
        if (clear_i || tmo_o) begin
            count_d = '0;
            timer_d = '0;
        end else begin
            if (issue_i && !done_i) begin
                if (!full_o) count_d = count_q + 1'b1;
            end else if (done_i && !issue_i && busy) begin
                count_d = count_q - 1'b1;
            end
            if (done_i || !busy || (TIMEOUT == 0)) timer_d = '0;
            else                                   timer_d = timer_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            timer_q <= '0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin Wishbone (pipelined) arbiter with depth throttle and timeout abort.
// Handshake: a request transfers on a cycle where s_stb=1 and s_stall=0; each transfer
// is completed by exactly one cycle of s_ack or s_err (err wins if both are high).
module bus_arbiter2
    import bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_cyc,
    input  logic                     m0_stb,
    input  logic                     m0_we,
    input  logic [BUS_ADDRWIDTH-1:0] m0_addr,
    input  logic [BUS_DATAWIDTH-1:0] m0_data_m2s,
    input  logic [BUS_SELWIDTH-1:0]  m0_sel,
    output logic [BUS_DATAWIDTH-1:0] m0_data_s2m,
    output logic                     m0_ack,
    output logic                     m0_err,
    output logic                     m0_stall,
    input  logic                     m1_cyc,
    input  logic                     m1_stb,
    input  logic                     m1_we,
    input  logic [BUS_ADDRWIDTH-1:0] m1_addr,
    input  logic [BUS_DATAWIDTH-1:0] m1_data_m2s,
    input  logic [BUS_SELWIDTH-1:0]  m1_sel,
    output logic [BUS_DATAWIDTH-1:0] m1_data_s2m,
    output logic                     m1_ack,
    output logic                     m1_err,
    output logic                     m1_stall,
    output logic                     s_cyc,
    output logic                     s_stb,
    output logic                     s_we,
    output logic [BUS_ADDRWIDTH-1:0] s_addr,
    output logic [BUS_DATAWIDTH-1:0] s_data_m2s,
    output logic [BUS_SELWIDTH-1:0]  s_sel,
    input  logic [BUS_DATAWIDTH-1:0] s_data_s2m,
    input  logic                     s_ack,
    input  logic                     s_err,
    input  logic                     s_stall,
    output arb_state_e               dbg_state,
    output logic [CW-1:0]            dbg_outstanding
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // index of the master that owned the bus most recently

    logic                     own_is_m1;
    logic                     own_cyc, own_stb, own_we;
    logic [BUS_ADDRWIDTH-1:0] own_addr;
    logic [BUS_DATAWIDTH-1:0] own_data;
    logic [BUS_SELWIDTH-1:0]  own_sel;
    logic                     issue, done, clear, full, tmo;

    // In TERM the owner is remembered in last_q, which is written on entry.
    assign own_is_m1 = (state_q == ARB_GNT1) || ((state_q == ARB_TERM) && last_q);
    assign own_cyc   = own_is_m1 ? m1_cyc      : m0_cyc;
    assign own_stb   = own_is_m1 ? m1_stb      : m0_stb;
    assign own_we    = own_is_m1 ? m1_we       : m0_we;
    assign own_addr  = own_is_m1 ? m1_addr     : m0_addr;
    assign own_data  = own_is_m1 ? m1_data_m2s : m0_data_m2s;
    assign own_sel   = own_is_m1 ? m1_sel      : m0_sel;

    assign m0_data_s2m     = s_data_s2m;
    assign m1_data_s2m     = s_data_s2m;
    assign dbg_state       = state_q;

    bus_txn_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TIMEOUT         (TIMEOUT)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue_i (issue),
        .done_i  (done),
        .clear_i (clear),
        .full_o  (full),
        .tmo_o   (tmo),
        .count_o (dbg_outstanding)
    );

    // Arbitration FSM next state plus all bus muxing and master responses.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_data_m2s = '0;
        s_sel      = '0;
        m0_ack     = 1'b0;
        m0_err     = 1'b0;
        m0_stall   = 1'b1;
        m1_ack     = 1'b0;
        m1_err     = 1'b0;
        m1_stall   = 1'b1;
        issue      = 1'b0;
        done       = 1'b0;
        clear      = 1'b1;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_cyc && m1_cyc) state_d = last_q ? ARB_GNT0 : ARB_GNT1;
                else if (m0_cyc)      state_d = ARB_GNT0;
                else if (m1_cyc)      state_d = ARB_GNT1;
            end
            ARB_GNT0, ARB_GNT1: begin
                clear      = !own_cyc;
                done       = s_ack | s_err;
                s_cyc      = own_cyc;
                s_stb      = own_cyc & own_stb & !full;
                s_we       = own_we;
                s_addr     = own_addr;
                s_data_m2s = own_data;
                s_sel      = own_sel;
                issue      = own_cyc & own_stb & !full & !s_stall;
                if (own_is_m1) begin
                    m1_stall = s_stall | full;
                    m1_ack   = s_ack & !s_err;
                    m1_err   = s_err | tmo;
                end else begin
                    m0_stall = s_stall | full;
                    m0_ack   = s_ack & !s_err;
                    m0_err   = s_err | tmo;
                end
                if (!own_cyc) begin
                    state_d = ARB_IDLE;
                    last_d  = own_is_m1;
                end else if (tmo) begin
                    state_d = ARB_TERM;
                    last_d  = own_is_m1;
                end
            end
            ARB_TERM: begin
                if (!own_cyc) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and round-robin pointer; m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 with a cycle-level reference model.
module tb_bus_arbiter2;
    import bus_pkg::*;

    localparam int MAXO = 4;
    localparam int TMO  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [29:0] m0_addr = '0;
    logic [31:0] m0_data_m2s = '0;
    logic [3:0]  m0_sel = '0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [29:0] m1_addr = '0;
    logic [31:0] m1_data_m2s = '0;
    logic [3:0]  m1_sel = '0;
    logic [31:0] s_data_s2m = '0;
    logic        s_ack = 0, s_err = 0, s_stall = 0;

    logic [31:0] m0_data_s2m, m1_data_s2m, s_data_m2s;
    logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [29:0] s_addr;
    logic [3:0]  s_sel;
    arb_state_e  dbg_state;
    logic [2:0]  dbg_outstanding;

    bus_arbiter2 #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_data_m2s(m0_data_m2s), .m0_sel(m0_sel), .m0_data_s2m(m0_data_s2m),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_data_m2s(m1_data_m2s), .m1_sel(m1_sel), .m1_data_s2m(m1_data_s2m),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_data_m2s(s_data_m2s), .s_sel(s_sel), .s_data_s2m(s_data_s2m),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
        .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding)
    );

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;            // downstream transfers seen (s_stb & !s_stall)
    logic [31:0] exp_q[$];       // read data expected with each master ack

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // owner: -1 bus free, 0/1 master holding the bus; aborted: owner's cycle was killed by timeout.
    int   mo_owner = -1;
    bit   mo_aborted = 0;
    int   mo_last = 1;
    int   mo_pend = 0;
    int   mo_wait = 0;

    logic        c_cyc, c_stb, c_we, active, dn, full, tmo_e, e_stb, acc;
    logic [29:0] c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_sel;
    logic        e_stall, e_ack, e_err;

    // One compare per cycle on the falling edge, then advance the model.
    always @(negedge clk) begin
        if (!rst) begin
            mo_owner = -1; mo_aborted = 0; mo_last = 1; mo_pend = 0; mo_wait = 0;
            check("rst_s_cyc", s_cyc, 0);
            check("rst_s_stb", s_stb, 0);
            check("rst_m0_stall", m0_stall, 1);
            check("rst_m1_stall", m1_stall, 1);
        end else begin
            if (s_stb && !s_stall) acc_cnt++;
            c_cyc  = (mo_owner == 1) ? m1_cyc      : m0_cyc;
            c_stb  = (mo_owner == 1) ? m1_stb      : m0_stb;
            c_we   = (mo_owner == 1) ? m1_we       : m0_we;
            c_addr = (mo_owner == 1) ? m1_addr     : m0_addr;
            c_data = (mo_owner == 1) ? m1_data_m2s : m0_data_m2s;
            c_sel  = (mo_owner == 1) ? m1_sel      : m0_sel;
            active = (mo_owner >= 0) && !mo_aborted;
            dn     = s_ack || s_err;
            full   = (mo_pend == MAXO);
            tmo_e  = active && (mo_pend > 0) && !dn && (mo_wait == TMO - 1);
            e_stb  = active && c_cyc && c_stb && !full;
            e_stall = active ? (s_stall || full) : 1'b1;
            e_ack  = active && s_ack && !s_err;
            e_err  = active && (s_err || tmo_e);

            check("m_s_cyc", s_cyc, active && c_cyc);
            check("m_s_stb", s_stb, e_stb);
            check("m_s_we", s_we, active && c_we);
            check("m_s_addr", s_addr, active ? c_addr : 30'h0);
            check("m_s_data_m2s", s_data_m2s, active ? c_data : 32'h0);
            check("m_s_sel", s_sel, active ? c_sel : 4'h0);
            check("m_m0_stall", m0_stall, (mo_owner == 0) ? e_stall : 1'b1);
            check("m_m1_stall", m1_stall, (mo_owner == 1) ? e_stall : 1'b1);
            check("m_m0_ack", m0_ack, (mo_owner == 0) && e_ack);
            check("m_m1_ack", m1_ack, (mo_owner == 1) && e_ack);
            check("m_m0_err", m0_err, (mo_owner == 0) && e_err);
            check("m_m1_err", m1_err, (mo_owner == 1) && e_err);
            check("m_m0_data_s2m", m0_data_s2m, s_data_s2m);
            check("m_m1_data_s2m", m1_data_s2m, s_data_s2m);
            check("m_outstanding", dbg_outstanding, mo_pend);

            // scoreboard: every master ack must deliver the next expected read word
            if (m0_ack || m1_ack) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_unexpected_ack: got ack with empty queue at %0t", $time);
                end else begin
                    check("sb_rdata", m0_ack ? m0_data_s2m : m1_data_s2m, exp_q.pop_front());
                end
            end

            // model advance for the coming rising edge
            if (mo_owner < 0) begin
                mo_pend = 0; mo_wait = 0;
                if (m0_cyc && m1_cyc) mo_owner = (mo_last == 1) ? 0 : 1;
                else if (m0_cyc)      mo_owner = 0;
                else if (m1_cyc)      mo_owner = 1;
            end else if (mo_aborted) begin
                if (!c_cyc) begin mo_last = mo_owner; mo_owner = -1; mo_aborted = 0; end
            end else if (!c_cyc) begin
                mo_last = mo_owner; mo_owner = -1; mo_pend = 0; mo_wait = 0;
            end else if (tmo_e) begin
                mo_aborted = 1; mo_pend = 0; mo_wait = 0;
            end else begin
                acc = e_stb && !s_stall;
                if (dn || mo_pend == 0) mo_wait = 0;
                else                    mo_wait = mo_wait + 1;
                if (acc && !dn)                    mo_pend = mo_pend + 1;
                else if (dn && !acc && mo_pend > 0) mo_pend = mo_pend - 1;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: stimulus did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    int acc0;
    initial begin
        step(); step();
        check("rst_state", dbg_state, ARB_IDLE);
        check("rst_outstanding", dbg_outstanding, 0);
        check("rst_s_addr", s_addr, 0);
        rst = 1'b1;

        // 1: single read from m0, ack two cycles after issue
        step(); m0_cyc = 1; m0_stb = 1; m0_addr = 30'h10; m0_sel = 4'hf; #1;
        check("t1_arb_latency_s_cyc", s_cyc, 0);
        check("t1_idle_m0_stall", m0_stall, 1);
        step(); #1;
        check("t1_gnt_s_cyc", s_cyc, 1);
        check("t1_gnt_s_stb", s_stb, 1);
        check("t1_gnt_s_addr", s_addr, 30'h10);
        check("t1_gnt_m0_stall", m0_stall, 0);
        step(); m0_stb = 0; #1;
        check("t1_outstanding", dbg_outstanding, 1);
        step(); s_ack = 1; s_data_s2m = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF); #1;
        check("t1_m0_ack", m0_ack, 1);
        check("t1_m0_data", m0_data_s2m, 32'hDEADBEEF);
        check("t1_m1_stall", m1_stall, 1);
        step(); s_ack = 0; s_data_s2m = 0; m0_cyc = 0; #1;
        check("t1_drained", dbg_outstanding, 0);
        check("t1_cyc_drop", s_cyc, 0);
        step();

        // 2: round-robin alternation from reset
        rst = 0; step(); step(); rst = 1;
        step(); m0_cyc = 1; m1_cyc = 1; #1;
        check("t2_idle", dbg_state, ARB_IDLE);
        step(); #1;
        check("t2_first_gnt0", dbg_state, ARB_GNT0);
        check("t2_m1_stall", m1_stall, 1);
        step(); m0_cyc = 0; #1;
        check("t2_m0_release_s_cyc", s_cyc, 0);
        step(); #1;
        check("t2_back_idle", dbg_state, ARB_IDLE);
        step(); #1;
        check("t2_then_gnt1", dbg_state, ARB_GNT1);
        check("t2_gnt1_m0_stall", m0_stall, 1);
        step(); m1_cyc = 0; m0_cyc = 1;
        step(); #1;
        check("t2_idle_again", dbg_state, ARB_IDLE);
        m1_cyc = 1;
        step(); #1;
        check("t2_tie_to_gnt0", dbg_state, ARB_GNT0);
        step(); m0_cyc = 0; m1_cyc = 0;
        step(); step();

        // 3: depth limit, m0 streams writes with no acks
        step(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 30'h100; m0_data_m2s = 32'h12345678;
        step();
        acc0 = acc_cnt;
        repeat (5) step();
        check("t3_accepted_4", acc_cnt - acc0, 4);
        check("t3_full_stall", m0_stall, 1);
        check("t3_full_count", dbg_outstanding, 4);
        step(); s_ack = 1; s_data_s2m = 32'hA5A50001; exp_q.push_back(32'hA5A50001); #1;
        check("t3_stall_during_ack", m0_stall, 1);
        step(); s_ack = 0; s_data_s2m = 0; #1;
        check("t3_fifth_stb", s_stb, 1);
        check("t3_fifth_unstall", m0_stall, 0);
        step(); m0_stb = 0; m0_cyc = 0; m0_we = 0; #1;
        check("t3_accepted_5", acc_cnt - acc0, 5);
        step(); step();

        // 4: timeout abort after 8 silent cycles
        step(); m0_cyc = 1; m0_stb = 1; m0_addr = 30'h20;
        step();
        step(); m0_stb = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check("t4_err_pulse", m0_err, (k == 8));
            if (k >= 9) begin
                check("t4_term_s_cyc", s_cyc, 0);
                check("t4_term_state", dbg_state, ARB_TERM);
            end
            step();
        end
        s_ack = 1; #1;
        check("t4_late_ack_dropped", m0_ack, 0);
        check("t4_term_stall", m0_stall, 1);
        step(); s_ack = 0; m0_cyc = 0; #1;
        check("t4_hold_term", dbg_state, ARB_TERM);
        step(); #1;
        check("t4_release_idle", dbg_state, ARB_IDLE);
        step();

        // 5: ack and err together -> single error completion
        step(); m0_cyc = 1; m0_stb = 1;
        step();
        step(); m0_stb = 0;
        step(); s_ack = 1; s_err = 1; #1;
        check("t5_err_wins", m0_err, 1);
        check("t5_no_ack", m0_ack, 0);
        step(); s_ack = 0; s_err = 0; #1;
        check("t5_outstanding0", dbg_outstanding, 0);
        check("t5_err_cleared", m0_err, 0);
        m0_cyc = 0;
        step(); step();

        // 6: asynchronous reset mid-burst
        step(); m0_cyc = 1; m0_stb = 1; m0_addr = 30'h3ff;
        step();
        step(); step(); step(); #1;
        check("t6_outstanding3", dbg_outstanding, 3);
        check("t6_pre_s_stb", s_stb, 1);
        #1 rst = 0; #1;
        check("t6_s_cyc", s_cyc, 0);
        check("t6_s_stb", s_stb, 0);
        check("t6_s_addr", s_addr, 0);
        check("t6_m0_stall", m0_stall, 1);
        check("t6_m1_stall", m1_stall, 1);
        check("t6_m0_ack", m0_ack, 0);
        check("t6_state", dbg_state, ARB_IDLE);
        check("t6_outstanding0", dbg_outstanding, 0);
        step(); step();
        rst = 1; m0_cyc = 0; m0_stb = 0;
        step(); step();

        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
